// File: rtl/atm_pkg.sv
// atm_pkg: op codes, status codes and FSM state encoding shared with the ATM front-end. Rev 1.0
`default_nettype none

package atm_pkg;

  typedef enum logic [2:0] {
    OP_VERIFY   = 3'd0,
    OP_WITHDRAW = 3'd1,
    OP_DEPOSIT  = 3'd2,
    OP_BALANCE  = 3'd3,
    OP_CLOSE    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_BAD_PIN      = 3'd1,
    ST_LOCKED       = 3'd2,
    ST_INSUFFICIENT = 3'd3,
    ST_NO_SESSION   = 3'd4,
    ST_BAD_CARD     = 3'd5,
    ST_OVERFLOW     = 3'd6,
    ST_ABORTED      = 3'd7
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/atm_account_server_alu.sv
// atm_acct_alu: combinational withdraw/deposit arithmetic with underflow/overflow flags. Rev 1.0
`default_nettype none

module atm_acct_alu #(
  parameter int BALANCE_WIDTH = 20
) (
  input  logic [BALANCE_WIDTH-1:0] balance,
  input  logic [BALANCE_WIDTH-1:0] value,
  output logic [BALANCE_WIDTH-1:0] wd_result,
  output logic                     underflow,
  output logic [BALANCE_WIDTH-1:0] dep_result,
  output logic                     overflow
);

  logic [BALANCE_WIDTH:0] sum;

  assign sum        = {1'b0, balance} + {1'b0, value};
  assign dep_result = sum[BALANCE_WIDTH-1:0];
  assign overflow   = sum[BALANCE_WIDTH];
  assign underflow  = value > balance;
  assign wd_result  = balance - value;

endmodule

`default_nettype wire

// File: rtl/atm_account_server.sv
// atm_account_server: account table plus single-session request/response server. Rev 1.0
`default_nettype none

module atm_account_server
  import atm_pkg::*;
#(
  parameter int BALANCE_WIDTH = 20,
  parameter int NUM_ACCOUNTS  = 4,
  parameter int CARD_WIDTH    = 2,
  parameter int PIN_WIDTH     = 16,
  parameter int MAX_TRIES     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [CARD_WIDTH-1:0]    req_card_id,
  input  logic [PIN_WIDTH-1:0]     req_pin,
  input  logic [BALANCE_WIDTH-1:0] req_value,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_status,
  output logic [BALANCE_WIDTH-1:0] rsp_balance,
  input  logic                     session_abort,
  output logic                     session_active,
  input  logic                     prov_we,
  input  logic [CARD_WIDTH-1:0]    prov_idx,
  input  logic [PIN_WIDTH-1:0]     prov_pin,
  input  logic [BALANCE_WIDTH-1:0] prov_balance
);

  localparam logic [CARD_WIDTH:0] NUM_ACC_W = (CARD_WIDTH + 1)'(NUM_ACCOUNTS);
  localparam logic [1:0]          MAX_T     = 2'(MAX_TRIES);

  logic [PIN_WIDTH-1:0]     pin_tbl    [NUM_ACCOUNTS];
  logic [BALANCE_WIDTH-1:0] bal_tbl    [NUM_ACCOUNTS];
  logic [1:0]               tries_tbl  [NUM_ACCOUNTS];
  logic                     locked_tbl [NUM_ACCOUNTS];

  state_e state, state_nxt;

  logic [2:0]               op_q;
  logic [CARD_WIDTH-1:0]    card_q;
  logic [PIN_WIDTH-1:0]     pin_q;
  logic [BALANCE_WIDTH-1:0] value_q;

  logic                     ent_ok;
  logic [PIN_WIDTH-1:0]     ent_pin;
  logic [BALANCE_WIDTH-1:0] ent_bal;
  logic [1:0]               ent_tries;
  logic                     ent_locked;

  logic                  sess_open;
  logic [CARD_WIDTH-1:0] sess_card;

  logic                  card_ok, prov_ok;
  logic [CARD_WIDTH-1:0] look_idx;

  // Out-of-range ids read entry 0 but are flagged invalid, so nothing downstream uses it.
  assign card_ok  = {1'b0, card_q} < NUM_ACC_W;
  assign prov_ok  = {1'b0, prov_idx} < NUM_ACC_W;
  assign look_idx = card_ok ? card_q : '0;

  assign req_ready      = !rst && (state == S_IDLE) && !prov_we;
  assign session_active = sess_open;

  logic [BALANCE_WIDTH-1:0] wd_result, dep_result;
  logic                     underflow, overflow;

  atm_acct_alu #(.BALANCE_WIDTH(BALANCE_WIDTH)) u_alu (
    .balance    (ent_bal),
    .value      (value_q),
    .wd_result  (wd_result),
    .underflow  (underflow),
    .dep_result (dep_result),
    .overflow   (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid && req_ready) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  status_e                  ex_status;
  logic [BALANCE_WIDTH-1:0] ex_bal;
  logic                     ex_wr_bal, ex_wr_tries, ex_lock, ex_sess_set, ex_sess_clr;
  logic [BALANCE_WIDTH-1:0] ex_new_bal;
  logic [1:0]               ex_new_tries;
  logic                     has_sess;

  assign has_sess = sess_open && (sess_card == card_q);

  always_comb begin
    ex_status    = ST_OK;
    ex_bal       = ent_bal;
    ex_wr_bal    = 1'b0;
    ex_new_bal   = ent_bal;
    ex_wr_tries  = 1'b0;
    ex_new_tries = ent_tries;
    ex_lock      = ent_locked;
    ex_sess_set  = 1'b0;
    ex_sess_clr  = 1'b0;
    if (session_abort) begin
      ex_status   = ST_ABORTED;
      ex_sess_clr = 1'b1;
    end else if (!ent_ok) begin
      ex_status = ST_BAD_CARD;
      ex_bal    = '0;
    end else if (op_q == OP_VERIFY) begin
      if (ent_locked) begin
        ex_status = ST_LOCKED;
      end else if (pin_q == ent_pin) begin
        ex_wr_tries  = 1'b1;
        ex_new_tries = 2'd0;
        ex_sess_set  = 1'b1;
      end else begin
        ex_wr_tries  = 1'b1;
        ex_new_tries = ent_tries + 2'd1;
        ex_sess_clr  = 1'b1;
        if (ex_new_tries == MAX_T) begin
          ex_lock   = 1'b1;
          ex_status = ST_LOCKED;
        end else begin
          ex_status = ST_BAD_PIN;
        end
      end
    end else if (!has_sess) begin
      ex_status = ST_NO_SESSION;
    end else begin
      case (op_q)
        OP_WITHDRAW: begin
          if (underflow) ex_status = ST_INSUFFICIENT;
          else begin
            ex_wr_bal  = 1'b1;
            ex_new_bal = wd_result;
            ex_bal     = wd_result;
          end
        end
        OP_DEPOSIT: begin
          if (overflow) ex_status = ST_OVERFLOW;
          else begin
            ex_wr_bal  = 1'b1;
            ex_new_bal = dep_result;
            ex_bal     = dep_result;
          end
        end
        OP_BALANCE: ex_status = ST_OK;
        OP_CLOSE:   ex_sess_clr = 1'b1;
        default:    ex_status = ST_ABORTED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_tbl[i]    <= '0;
        bal_tbl[i]    <= '0;
        tries_tbl[i]  <= '0;
        locked_tbl[i] <= 1'b0;
      end
      op_q        <= '0;
      card_q      <= '0;
      pin_q       <= '0;
      value_q     <= '0;
      ent_ok      <= 1'b0;
      ent_pin     <= '0;
      ent_bal     <= '0;
      ent_tries   <= '0;
      ent_locked  <= 1'b0;
      sess_open   <= 1'b0;
      sess_card   <= '0;
      rsp_valid   <= 1'b0;
      rsp_status  <= '0;
      rsp_balance <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (prov_we) begin
            if (prov_ok) begin
              pin_tbl[prov_idx]    <= prov_pin;
              bal_tbl[prov_idx]    <= prov_balance;
              tries_tbl[prov_idx]  <= '0;
              locked_tbl[prov_idx] <= 1'b0;
            end
          end else if (req_valid) begin
            op_q    <= req_op;
            card_q  <= req_card_id;
            pin_q   <= req_pin;
            value_q <= req_value;
          end
        end
        S_LOOKUP: begin
          ent_ok     <= card_ok;
          ent_pin    <= card_ok ? pin_tbl[look_idx] : '0;
          ent_bal    <= card_ok ? bal_tbl[look_idx] : '0;
          ent_tries  <= card_ok ? tries_tbl[look_idx] : '0;
          ent_locked <= card_ok ? locked_tbl[look_idx] : 1'b0;
        end
        S_EXEC: begin
          if (ex_wr_bal) bal_tbl[card_q] <= ex_new_bal;
          if (ex_wr_tries) begin
            tries_tbl[card_q]  <= ex_new_tries;
            locked_tbl[card_q] <= ex_lock;
          end
          rsp_valid   <= 1'b1;
          rsp_status  <= ex_status;
          rsp_balance <= ex_bal;
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase

      // Abort wins over every other session update on the same edge.
      if (session_abort) begin
        sess_open <= 1'b0;
      end else if (state == S_IDLE && prov_we && prov_ok && sess_card == prov_idx) begin
        sess_open <= 1'b0;
      end else if (state == S_EXEC && ex_sess_set) begin
        sess_open <= 1'b1;
        sess_card <= card_q;
      end else if (state == S_EXEC && ex_sess_clr) begin
        sess_open <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
